// File: rtl/bb_dual_arbiter_if.sv
// Request/grant bundle between the two side controllers, the bridge and bb_dual_arbiter.
// master: requesters and bridge drive req/bus_done; slave: the arbiter drives grants and status.
interface bb_dual_arbiter_if;
    logic req_a;
    logic req_b;
    logic bus_done;
    logic grant_a;
    logic grant_b;
    logic bus_sel;
    logic bus_start;
    logic timeout;
    logic busy;

    modport master (
        output req_a, req_b, bus_done,
        input  grant_a, grant_b, bus_sel, bus_start, timeout, busy
    );

    modport slave (
        input  req_a, req_b, bus_done,
        output grant_a, grant_b, bus_sel, bus_start, timeout, busy
    );
endinterface

// File: rtl/bb_dual_arbiter.sv
// Two-master arbiter for the shared bus bridge: round robin on ties, timeout and idle gap.
// Define ARB_FIXED_PRIO_EN to make side A win every tie instead (B may starve).
module bb_dual_arbiter #(
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned IDLE_GAP = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rstn,
    bb_dual_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IDLE_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             grant_a_q, grant_a_d;
    logic             grant_b_q, grant_b_d;
    logic             start_q, start_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             pick;
    logic             owner_req;
    logic             rel_grant;
`ifndef ARB_FIXED_PRIO_EN
    logic             last_q, last_d;
`endif

    // Side chosen when leaving IDLE: 0 = A, 1 = B.
`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~bus.req_a;
`else
    assign pick = (bus.req_a && bus.req_b) ? ~last_q : ~bus.req_a;
`endif

    assign owner_req = sel_q ? bus.req_b : bus.req_a;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        sel_d     = sel_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        rel_grant = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.req_a || bus.req_b) begin
                    state_d = ST_GRANT;
                    sel_d   = pick;
                    start_d = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = pick;
`endif
                end
            end
            ST_GRANT: begin
                // Completion and abort both outrank the timeout check.
                if (bus.bus_done || !owner_req) begin
                    rel_grant = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rel_grant = 1'b1;
                    timeout_d = 1'b1;
                end
                if (rel_grant) begin
                    cnt_d   = '0;
                    state_d = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        grant_a_d = (state_d == ST_GRANT) && !sel_d;
        grant_b_d = (state_d == ST_GRANT) &&  sel_d;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // B is the last owner after reset so A wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif

    assign bus.grant_a   = grant_a_q;
    assign bus.grant_b   = grant_b_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_start = start_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
        !(grant_a_q && grant_b_q));

endmodule

// File: tb/tb_bb_dual_arbiter.sv
// Self-checking bench for bb_dual_arbiter: directed vector table, corner sequences,
// and randomized traffic compared against a countdown-style reference model.
module tb_bb_dual_arbiter;

    localparam int TIMEOUT  = 16;
    localparam int IDLE_GAP = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bb_dual_arbiter_if bif();

    bb_dual_arbiter #(
        .TIMEOUT (TIMEOUT),
        .IDLE_GAP(IDLE_GAP),
        .CNT_W   (16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner -1/0/1, age = grant cycles already completed, gap = cycles left.
    int m_owner;
    int m_age;
    int m_gap;
    bit m_last;
    bit m_sel;
    bit m_start;
    bit m_to;

    typedef struct {
        bit         ra;
        bit         rb;
        bit         done;
        logic [5:0] exp;   // {grant_a, grant_b, bus_sel, bus_start, timeout, busy}
    } vec_t;

    vec_t vecs[15];

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_gap   = 0;
        m_last  = 1'b1;
        m_sel   = 1'b0;
        m_start = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input bit ra, input bit rb, input bit done);
        bit want;
        m_start = 1'b0;
        m_to    = 1'b0;
        if (m_owner >= 0) begin
            want = (m_owner == 1) ? rb : ra;
            if (done || !want) begin
                m_owner = -1;
                m_gap   = IDLE_GAP;
            end else if (TIMEOUT != 0 && m_age + 1 == TIMEOUT) begin
                m_owner = -1;
                m_gap   = IDLE_GAP;
                m_to    = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (ra || rb) begin
`ifdef ARB_FIXED_PRIO_EN
            m_owner = ra ? 0 : 1;
`else
            if (ra && rb) m_owner = m_last ? 0 : 1;
            else          m_owner = ra ? 0 : 1;
`endif
            m_age   = 0;
            m_sel   = (m_owner == 1);
            m_last  = (m_owner == 1);
            m_start = 1'b1;
        end
    endtask

    function automatic logic [5:0] model_out();
        return {m_owner == 0, m_owner == 1, m_sel, m_start, m_to,
                (m_owner >= 0) || (m_gap > 0)};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bif.grant_a, bif.grant_b, bif.bus_sel, bif.bus_start, bif.timeout, bif.busy};
    endfunction

    task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b (ga gb sel start to busy)", nm, act, exp);
        end
    endtask

    task automatic tick();
        if (rstn) model_step(bif.req_a, bif.req_b, bif.bus_done);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bif.req_a    = 1'b0;
        bif.req_b    = 1'b0;
        bif.bus_done = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_own;
        bit         got;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'b100101};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 6'b100001};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 6'b000001};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'b000001};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'b011101};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'b001001};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 6'b001001};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'b001000};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 6'b001000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 6'b100101};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 6'b000001};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 6'b000001};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 6'b000000};

        do_reset();
        chk6("reset_state", dut_out(), 6'b000000);

        for (int i = 0; i < 15; i++) begin
            bif.req_a    = vecs[i].ra;
            bif.req_b    = vecs[i].rb;
            bif.bus_done = vecs[i].done;
            tick();
            chk6($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end
        bif.bus_done = 1'b0;

        // Timeout: B holds its request for the whole window.
        bif.req_b = 1'b1;
        tick();
        chk6("to_grant", dut_out(), 6'b011101);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            chk6($sformatf("to_hold%0d", i), dut_out(), 6'b011001);
        end
        tick();
        chk6("to_pulse", dut_out(), 6'b001011);
        bif.req_b = 1'b0;
        tick();
        chk6("to_gap2", dut_out(), 6'b001001);
        tick();
        chk6("to_idle", dut_out(), 6'b001000);

        // Asynchronous reset in the middle of a B grant.
        bif.req_b = 1'b1;
        tick();
        chk6("rst_pre_grant", dut_out(), 6'b011101);
        tick();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk6("rst_async", dut_out(), 6'b000000);
        @(posedge clk);
        #1;
        bif.req_a = 1'b1;
        bif.req_b = 1'b1;
        rstn = 1'b1;
        tick();
        chk6("rst_tie_a", dut_out(), 6'b100101);

        // Both sides keep requesting; every completion re-arbitrates.
        for (int k = 0; k < 4; k++) begin
            bif.bus_done = 1'b1;
            tick();
            bif.bus_done = 1'b0;
            chk6($sformatf("rr_drop%0d", k), {4'b0, bif.grant_a, bif.grant_b}, 6'b0);
            got = 1'b0;
            for (int n = 0; n < 8 && !got; n++) begin
                tick();
                got = bif.grant_a | bif.grant_b;
            end
`ifdef ARB_FIXED_PRIO_EN
            exp_own = 2'b10;
`else
            exp_own = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk6($sformatf("rr_owner%0d", k),
                 {3'b0, bif.grant_a, bif.grant_b, bif.bus_start},
                 {3'b0, exp_own, 1'b1});
        end
        bif.req_a = 1'b0;
        bif.req_b = 1'b0;
        repeat (4) tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int flip_rng;
            int done_rng;
            flip_rng = ((i / 500) % 2 == 0) ? 3 : 30;
            done_rng = ((i / 250) % 3 == 2) ? 40 : 5;
            if ($urandom_range(flip_rng) == 0) bif.req_a = ~bif.req_a;
            if ($urandom_range(flip_rng) == 0) bif.req_b = ~bif.req_b;
            bif.bus_done = ($urandom_range(done_rng) == 0);
            tick();
            chk6($sformatf("rand%0d", i), dut_out(), model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
